// File: rtl/jtdd2_adpcm_cache_pkg.sv
`default_nettype none
//==============================================================================
// Module : jtdd2_adpcm_cache_pkg
// Brief  : State encoding and line geometry shared by the ADPCM read cache.
// Rev    : 1.0  initial release
//==============================================================================
package jtdd2_adpcm_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } cache_state_t;

  localparam int c_LINE_BITS = 32;

endpackage
`default_nettype wire

// File: rtl/jtdd2_adpcm_line.sv
`default_nettype none
//==============================================================================
// Module : jtdd2_adpcm_line
// Brief  : One cache entry: valid/tag/data registers, hit compare, byte select.
// Rev    : 1.0  initial release
//==============================================================================
module jtdd2_adpcm_line
  import jtdd2_adpcm_cache_pkg::*;
#(
  parameter int TW = 16,
  parameter int LW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_we,
  input  logic [TW-1:0]          i_wr_tag,
  input  logic [c_LINE_BITS-1:0] i_wr_data,
  input  logic [TW-1:0]          i_rd_tag,
  input  logic [LW-1:0]          i_rd_sel,
  output logic                   o_valid,
  output logic [TW-1:0]          o_tag,
  output logic                   o_hit,
  output logic [7:0]             o_byte
);

  logic                   r_valid;
  logic [TW-1:0]          r_tag;
  logic [c_LINE_BITS-1:0] r_data;

  // Invalidate has priority over a fill arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
    end
  end

  assign o_valid = r_valid;
  assign o_tag   = r_tag;
  assign o_hit   = r_valid && (r_tag == i_rd_tag);
  assign o_byte  = r_data[{i_rd_sel, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/jtdd2_adpcm_cache.sv
`default_nettype none
//==============================================================================
// Module : jtdd2_adpcm_cache
// Brief  : Two-line ADPCM ROM read buffer with next-line prefetch on demand fill.
// Rev    : 1.0  initial release
//==============================================================================
module jtdd2_adpcm_cache
  import jtdd2_adpcm_cache_pkg::*;
#(
  parameter int AW = 18,
  parameter int LW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [AW-1:0]    addr,
  input  logic             cs,
  output logic [7:0]       dout,
  output logic             ok,
  output logic [AW-LW-1:0] mem_addr,
  output logic             mem_cs,
  input  logic [31:0]      mem_data,
  input  logic             mem_ok
);

  localparam int TW = AW - LW;

  cache_state_t  r_state;
  logic          r_lru;
  logic          r_target;
  logic          r_discard;
  logic          r_ok;
  logic          r_mem_cs;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_dout;
  logic [TW-1:0] r_mem_addr;

  logic [TW-1:0] w_tag;
  logic [LW-1:0] w_sel;
  logic [1:0]    w_valid;
  logic [1:0]    w_hit;
  logic [1:0]    w_we;
  logic [TW-1:0] w_line_tag  [2];
  logic [7:0]    w_line_byte [2];
  logic          w_any_hit;
  logic          w_fill;
  logic          w_next_res;
  logic [TW-1:0] w_next;

  assign w_tag      = addr[AW-1:LW];
  assign w_sel      = addr[LW-1:0];
  assign w_any_hit  = cs && (w_hit != 2'b00);
  // A returning line is kept only if no flush touched this request.
  assign w_fill     = r_mem_cs && mem_ok && !flush && !r_discard;
  assign w_next     = r_mem_addr + TW'(1);
  assign w_next_res = w_valid[~r_target] && (w_line_tag[~r_target] == w_next);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      assign w_we[gi] = w_fill && (r_target == 1'(gi));
      jtdd2_adpcm_line #(
        .TW (TW),
        .LW (LW)
      ) u_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (flush),
        .i_we      (w_we[gi]),
        .i_wr_tag  (r_mem_addr),
        .i_wr_data (mem_data),
        .i_rd_tag  (w_tag),
        .i_rd_sel  (w_sel),
        .o_valid   (w_valid[gi]),
        .o_tag     (w_line_tag[gi]),
        .o_hit     (w_hit[gi]),
        .o_byte    (w_line_byte[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lru      <= 1'b0;
      r_target   <= 1'b0;
      r_discard  <= 1'b0;
      r_ok       <= 1'b0;
      r_mem_cs   <= 1'b0;
      r_addr     <= '0;
      r_dout     <= '0;
      r_mem_addr <= '0;
    end else begin
      if (flush) begin
        r_ok <= 1'b0;
      end else if (w_any_hit) begin
        r_ok   <= 1'b1;
        r_addr <= addr;
        r_dout <= w_hit[0] ? w_line_byte[0] : w_line_byte[1];
        r_lru  <= w_hit[0];
      end
      case (r_state)
        ST_IDLE: begin
          if (cs && !w_any_hit && !flush) begin
            r_mem_addr <= w_tag;
            r_mem_cs   <= 1'b1;
            r_target   <= r_lru;
            r_discard  <= 1'b0;
            r_state    <= ST_DEMAND;
          end
        end
        ST_DEMAND: begin
          if (flush) r_discard <= 1'b1;
          if (mem_ok) begin
            r_mem_cs  <= 1'b0;
            r_discard <= 1'b0;
            if (!w_fill) begin
              r_state <= ST_IDLE;
            end else begin
              r_lru <= ~r_target;
              if (w_next_res) begin
                r_state <= ST_IDLE;
              end else begin
                // The other entry takes the prefetch; lru is left pointing at it.
                r_state    <= ST_PREFETCH;
                r_target   <= ~r_target;
                r_mem_addr <= w_next;
              end
            end
          end
        end
        ST_PREFETCH: begin
          if (!r_mem_cs) begin
            if (flush) r_state  <= ST_IDLE;
            else       r_mem_cs <= 1'b1;
          end else begin
            if (flush) r_discard <= 1'b1;
            if (mem_ok) begin
              r_mem_cs  <= 1'b0;
              r_discard <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dout     = r_dout;
  assign ok       = r_ok && cs && (addr == r_addr);
  assign mem_addr = r_mem_addr;
  assign mem_cs   = r_mem_cs;

endmodule
`default_nettype wire

// File: tb/tb_jtdd2_adpcm_cache.sv
`default_nettype none
//==============================================================================
// Module : tb_jtdd2_adpcm_cache
// Brief  : Self-checking bench with an SDRAM responder and a residency model.
// Rev    : 1.0  initial release
//==============================================================================
module tb_jtdd2_adpcm_cache;

  logic        clk = 1'b0;
  logic        rst_n, flush, cs, ok, mem_cs, mem_ok;
  logic [17:0] addr;
  logic [7:0]  dout;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;

  int tests = 0, fails = 0, cyc = 0, nreq = 0, mem_lat = 6;
  logic [15:0] exp_q[$];
  int          req_cyc[$];

  // Residency model: which lines each of the two entries holds, and the victim.
  logic        m_v[2];
  logic [15:0] m_t[2];
  int          m_lru;

  jtdd2_adpcm_cache #(.AW(18), .LW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .addr     (addr),
    .cs       (cs),
    .dout     (dout),
    .ok       (ok),
    .mem_addr (mem_addr),
    .mem_cs   (mem_cs),
    .mem_data (mem_data),
    .mem_ok   (mem_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] line_data(input logic [15:0] l);
    return 32'h40302010 + 32'(l) * 32'h04030201;
  endfunction

  function automatic logic [7:0] byte_of(input logic [17:0] a);
    logic [31:0] d;
    d = line_data(a[17:2]);
    return d[8*a[1:0] +: 8];
  endfunction

  // SDRAM responder: checks each request against the model's expected order.
  initial begin : sdram
    logic [15:0] ra;
    int          lat;
    mem_ok = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_cs === 1'b1) begin
        ra = mem_addr; lat = mem_lat;
        req_cyc.push_back(cyc); nreq++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL req_unexpected line=%h required none", ra);
        end else begin
          if (ra !== exp_q[0]) begin fails++; $display("FAIL req_order line=%h required %h", ra, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        repeat (lat) begin
          @(negedge clk);
          tests++;
          if (mem_cs !== 1'b1 || mem_addr !== ra) begin
            fails++; $display("FAIL req_hold cs=%b line=%h required 1/%h", mem_cs, mem_addr, ra);
          end
        end
        mem_data = line_data(ra); mem_ok = 1'b1;
        @(negedge clk);
        mem_ok = 1'b0; mem_data = '0;
        tests++;
        if (mem_cs !== 1'b0) begin fails++; $display("FAIL req_gap cs=%b required 0", mem_cs); end
      end
    end
  end

  task automatic model_access(input logic [15:0] l, output bit hit);
    int e;
    hit = 1'b0;
    for (int i = 0; i < 2; i++)
      if (m_v[i] && m_t[i] == l) begin hit = 1'b1; m_lru = 1 - i; end
    if (!hit) begin
      e = m_lru;
      m_v[e] = 1'b1; m_t[e] = l; exp_q.push_back(l); m_lru = 1 - e;
      if (!(m_v[1-e] && m_t[1-e] == l + 16'd1)) begin
        m_v[1-e] = 1'b1; m_t[1-e] = l + 16'd1; exp_q.push_back(l + 16'd1);
      end
    end
  endtask

  task automatic do_read(input logic [17:0] a, output int n, output logic [7:0] got);
    @(negedge clk);
    addr = a; cs = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ok && n < 300);
    got = dout;
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL read_timeout addr=%h ok=%b required 1", a, ok); end
  endtask

  task automatic do_flush;
    @(negedge clk); cs = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (2*mem_lat + 12) @(negedge clk);
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    exp_q.delete(); req_cyc.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; cs = 1'b0; addr = '0;
    m_v[0] = 1'b0; m_v[1] = 1'b0; m_lru = 0;
    repeat (3) @(negedge clk);
    tests++; if (dout !== 8'h00)     begin fails++; $display("FAIL reset_dout got=%h required 00", dout); end
    tests++; if (ok !== 1'b0)        begin fails++; $display("FAIL reset_ok got=%b required 0", ok); end
    tests++; if (mem_cs !== 1'b0)    begin fails++; $display("FAIL reset_mem_cs got=%b required 0", mem_cs); end
    tests++; if (mem_addr !== 16'h0) begin fails++; $display("FAIL reset_mem_addr got=%h required 0000", mem_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_read;
    int n; logic [7:0] got; bit hit;
    mem_lat = 6; req_cyc.delete();
    model_access(16'h0001, hit);
    do_read(18'h00005, n, got);
    tests++; if (got !== 8'h22) begin fails++; $display("FAIL cold_data got=%h required 22", got); end
    tests++; if (n != mem_lat + 3) begin fails++; $display("FAIL cold_latency got=%0d required %0d", n, mem_lat + 3); end
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++;
    if (req_cyc.size() != 2 || req_cyc[1] - req_cyc[0] != mem_lat + 2) begin
      fails++; $display("FAIL cold_prefetch_gap reqs=%0d required 2 with gap %0d", req_cyc.size(), mem_lat + 2);
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL cold_missing_req left=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_seq_sweep;
    int n, n0; logic [7:0] got; bit hit;
    do_flush; mem_lat = 10; n0 = nreq;
    for (int a = 0; a < 64; a++) begin
      model_access(16'(a >> 2), hit);
      do_read(18'(a), n, got);
      tests++; if (got !== byte_of(18'(a))) begin fails++; $display("FAIL sweep_data a=%h got=%h required %h", a, got, byte_of(18'(a))); end
      tests++; if (n != (hit ? 1 : mem_lat + 3)) begin fails++; $display("FAIL sweep_latency a=%h got=%0d required %0d", a, n, hit ? 1 : mem_lat + 3); end
      if (n < 45) repeat (45 - n) @(negedge clk);
    end
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++;
    if (nreq - n0 != 16 || exp_q.size() != 0) begin
      fails++; $display("FAIL sweep_req_count got=%0d required 16", nreq - n0);
    end
  endtask

  task automatic test_wrap;
    int n; logic [7:0] got; bit hit;
    do_flush; mem_lat = 4;
    model_access(16'hFFFF, hit);
    do_read(18'h3FFFC, n, got);
    tests++; if (got !== byte_of(18'h3FFFC)) begin fails++; $display("FAIL wrap_data got=%h required %h", got, byte_of(18'h3FFFC)); end
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL wrap_prefetch left=%0d required 0", exp_q.size()); end
    model_access(16'h0000, hit);
    do_read(18'h00000, n, got);
    tests++; if (n != 1) begin fails++; $display("FAIL wrap_hit_latency got=%0d required 1", n); end
    tests++; if (got !== byte_of(18'h00000)) begin fails++; $display("FAIL wrap_hit_data got=%h required %h", got, byte_of(18'h00000)); end
  endtask

  task automatic test_addr_change;
    int n; logic [7:0] got; bit hit;
    do_flush; mem_lat = 5;
    model_access(16'h0040, hit);
    do_read(18'h00100, n, got);
    repeat (2*mem_lat + 12) @(negedge clk);
    model_access(16'h0040, hit);
    do_read(18'h00101, n, got);
    tests++; if (n != 1) begin fails++; $display("FAIL chg_hit_latency got=%0d required 1", n); end
    model_access(16'h0800, hit);
    @(negedge clk);
    addr = 18'h02000;
    #1;
    tests++; if (ok !== 1'b0) begin fails++; $display("FAIL chg_ok_drop got=%b required 0", ok); end
    n = 0;
    do begin @(negedge clk); n++; end while (!ok && n < 300);
    tests++; if (n != mem_lat + 3) begin fails++; $display("FAIL chg_ok_low got=%0d required %0d", n, mem_lat + 3); end
    tests++; if (dout !== byte_of(18'h02000)) begin fails++; $display("FAIL chg_data got=%h required %h", dout, byte_of(18'h02000)); end
    repeat (2*mem_lat + 12) @(negedge clk);
  endtask

  task automatic test_miss_during_prefetch;
    int n; logic [7:0] got; bit hit;
    do_flush; mem_lat = 10;
    model_access(16'h0000, hit);
    model_access(16'h8000, hit);
    do_read(18'h00000, n, got);
    tests++; if (got !== byte_of(18'h00000)) begin fails++; $display("FAIL mdp_first_data got=%h required %h", got, byte_of(18'h00000)); end
    do_read(18'h20000, n, got);
    tests++; if (got !== byte_of(18'h20000)) begin fails++; $display("FAIL mdp_data got=%h required %h", got, byte_of(18'h20000)); end
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++;
    if (req_cyc.size() != 4 || req_cyc[2] - req_cyc[1] != mem_lat + 2) begin
      fails++; $display("FAIL mdp_order reqs=%0d required 4 with gap %0d", req_cyc.size(), mem_lat + 2);
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mdp_missing_req left=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_flush_mid_fetch;
    int n; logic [7:0] got; bit hit;
    do_flush; mem_lat = 10;
    model_access(16'h0100, hit);
    do_read(18'h00400, n, got);
    repeat (2*mem_lat + 12) @(negedge clk);
    exp_q.push_back(16'h00C0);
    @(negedge clk); addr = 18'h00300; cs = 1'b1;
    repeat (4) @(negedge clk);
    cs = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    m_v[0] = 1'b0; m_v[1] = 1'b0;
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL flush_req_issued left=%0d required 0", exp_q.size()); end
    model_access(16'h00C0, hit);
    do_read(18'h00300, n, got);
    tests++; if (n != (hit ? 1 : mem_lat + 3)) begin fails++; $display("FAIL flush_refetch_latency got=%0d required %0d", n, hit ? 1 : mem_lat + 3); end
    tests++; if (got !== byte_of(18'h00300)) begin fails++; $display("FAIL flush_refetch_data got=%h required %h", got, byte_of(18'h00300)); end
    repeat (2*mem_lat + 12) @(negedge clk);
    model_access(16'h0100, hit);
    do_read(18'h00400, n, got);
    tests++; if (n != (hit ? 1 : mem_lat + 3)) begin fails++; $display("FAIL flush_old_line latency=%0d required %0d", n, hit ? 1 : mem_lat + 3); end
    tests++; if (got !== byte_of(18'h00400)) begin fails++; $display("FAIL flush_old_data got=%h required %h", got, byte_of(18'h00400)); end
    repeat (2*mem_lat + 12) @(negedge clk);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL flush_missing_req left=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_random;
    int n; logic [7:0] got; bit hit;
    logic [15:0] base, l;
    logic [17:0] a;
    do_flush;
    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(1, 12);
      base = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'h1230;
      l = base + 16'($urandom_range(0, 5));
      a = {l, 2'($urandom_range(0, 3))};
      model_access(l, hit);
      do_read(a, n, got);
      tests++; if (got !== byte_of(a)) begin fails++; $display("FAIL rand_data a=%h got=%h required %h", a, got, byte_of(a)); end
      tests++; if (n != (hit ? 1 : mem_lat + 3)) begin fails++; $display("FAIL rand_latency a=%h got=%0d required %0d", a, n, hit ? 1 : mem_lat + 3); end
      repeat (2*mem_lat + 12) @(negedge clk);
    end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL rand_missing_req left=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_seq_sweep;
    test_wrap;
    test_addr_change;
    test_miss_during_prefetch;
    test_flush_mid_fetch;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
